// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam int                DEF_ADDR_STEP = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives an external PC register and a variable-latency
// instruction memory, and hands fetched words to decode through a valid/ready pair.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC  = DEF_RESET_PC,
    parameter int                ADDR_STEP = DEF_ADDR_STEP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               pc_load,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] ir_out,
    output logic [ADDR_W-1:0]  ir_pc,
    output logic               ir_valid,
    input  logic               ir_ready
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_next;
    logic               r_squash;
    logic               w_squash_next;
    logic [ADDR_W-1:0]  r_fetch_addr;
    logic [ADDR_W-1:0]  w_fetch_addr_next;
    logic [INSTR_W-1:0] r_ir_out;
    logic [INSTR_W-1:0] w_ir_out_next;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic [ADDR_W-1:0]  w_ir_pc_next;
    logic [ADDR_W-1:0]  w_seq_addr;

    // Wraps naturally at 2^32.
    assign w_seq_addr = r_fetch_addr + ADDR_W'(ADDR_STEP);

    always_comb begin
        w_state_next      = r_state;
        w_squash_next     = r_squash;
        w_fetch_addr_next = r_fetch_addr;
        w_ir_out_next     = r_ir_out;
        w_ir_pc_next      = r_ir_pc;
        pc_load           = 1'b0;
        pc_next           = pc_in;

        case (r_state)
            IDLE: begin
                // The address latched here predates any same-cycle redirect, so mark it stale.
                w_fetch_addr_next = pc_in;
                w_squash_next     = redirect;
                w_state_next      = WAIT;
            end
            WAIT: begin
                if (imem_ack) begin
                    if (redirect || r_squash) begin
                        w_squash_next = 1'b0;
                        w_state_next  = IDLE;
                    end else begin
                        pc_load       = 1'b1;
                        pc_next       = w_seq_addr;
                        w_ir_out_next = imem_rdata;
                        w_ir_pc_next  = r_fetch_addr;
                        w_state_next  = HOLD;
                    end
                end else if (redirect) begin
                    w_squash_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    w_state_next = IDLE;
                end else if (ir_ready) begin
                    w_fetch_addr_next = pc_in;
                    w_state_next      = WAIT;
                end
            end
            default: begin
                w_squash_next = 1'b0;
                w_state_next  = IDLE;
            end
        endcase

        if (redirect) begin
            pc_load = 1'b1;
            pc_next = redirect_target;
        end

        if (rst) begin
            pc_load = 1'b0;
            pc_next = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_squash     <= 1'b0;
            r_fetch_addr <= RESET_PC;
            r_ir_out     <= '0;
            r_ir_pc      <= RESET_PC;
        end else begin
            r_state      <= w_state_next;
            r_squash     <= w_squash_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_ir_out     <= w_ir_out_next;
            r_ir_pc      <= w_ir_pc_next;
        end
    end

    assign imem_req  = (r_state == WAIT) && !rst;
    assign imem_addr = r_fetch_addr;
    assign ir_valid  = (r_state == HOLD) && !rst;
    assign ir_out    = r_ir_out;
    assign ir_pc     = r_ir_pc;

endmodule
